// File: rtl/instruction_sequencer_if.sv
// Shared opcode definitions and the fetch/issue bus between the sequencer,
// its instruction ROM and the decode stage.
//
// Handshake: oValid/oInstruction belong to the sequencer and iReady to
// decode. An instruction transfers on a rising Clock edge where oValid and
// iReady are both high. While oValid is high and no transfer has happened,
// oInstruction stays constant and oValid stays high. The only exception is a
// redirect (iBranchTaken), which withdraws the offered instruction without a
// transfer. iReady may change freely and never depends on oValid.
`ifndef INSTRUCTION_SEQUENCER_DEFS
`define INSTRUCTION_SEQUENCER_DEFS
`define NOP 4'h0
`define STO 4'h5
`endif

interface instruction_sequencer_if;
  logic        iEnable;
  logic [15:0] oAddress;
  logic [27:0] iInstruction;
  logic [27:0] oInstruction;
  logic        oValid;
  logic        iReady;
  logic        iBranchTaken;
  logic [15:0] iBranchTarget;
  logic        oBusy;
  logic [1:0]  dbg_state;

  modport master (
    input  iEnable,
    output oAddress,
    input  iInstruction,
    output oInstruction,
    output oValid,
    input  iReady,
    input  iBranchTaken,
    input  iBranchTarget,
    output oBusy,
    output dbg_state
  );

  modport slave (
    output iEnable,
    input  oAddress,
    output iInstruction,
    input  oInstruction,
    input  oValid,
    output iReady,
    output iBranchTaken,
    output iBranchTarget,
    input  oBusy,
    input  dbg_state
  );
endinterface

// File: rtl/instruction_sequencer.sv
// Instruction sequencer: fetches from a combinational ROM at PC, offers the
// registered instruction to decode, and optionally stalls for a NOP's operand
// count. Branch redirects override everything else in every state.
module instruction_sequencer #(
  parameter logic [15:0] RESET_ADDR = 16'd0,
  parameter bit          DELAY_EN   = 1'b1
) (
  input logic                     Clock,
  input logic                     Reset,
  instruction_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    ISSUE = 2'd1,
    DELAY = 2'd2
  } state_t;

  state_t      state, state_n;
  logic [15:0] pc, pc_n;
  logic [27:0] ir, ir_n;
  logic [23:0] cnt, cnt_n;
  logic        stall_nop;

  // A NOP with a non-zero operand requests a stall of that many cycles.
  assign stall_nop = DELAY_EN && (ir[27:24] == `NOP) && (ir[23:0] != 24'd0);

  // State, PC, instruction register and stall counter.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= FETCH;
      pc    <= RESET_ADDR;
      ir    <= 28'd0;
      cnt   <= 24'd0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      ir    <= ir_n;
      cnt   <= cnt_n;
    end
  end

  // Next-state logic: redirect first, then fetch/handshake/stall progress.
  always_comb begin
    state_n = state;
    pc_n    = pc;
    ir_n    = ir;
    cnt_n   = cnt;
    case (state)
      FETCH: begin
        if (bus.iBranchTaken) begin
          pc_n = bus.iBranchTarget;
        end else if (bus.iEnable) begin
          ir_n    = bus.iInstruction;
          pc_n    = pc + 16'd1;
          state_n = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.iBranchTaken) begin
          pc_n    = bus.iBranchTarget;
          state_n = FETCH;
        end else if (bus.iReady) begin
          if (stall_nop) begin
            cnt_n   = ir[23:0];
            state_n = DELAY;
          end else begin
            state_n = FETCH;
          end
        end
      end
      DELAY: begin
        if (bus.iBranchTaken) begin
          pc_n    = bus.iBranchTarget;
          cnt_n   = 24'd0;
          state_n = FETCH;
        end else begin
          cnt_n = cnt - 24'd1;
          if (cnt <= 24'd1) begin
            cnt_n   = 24'd0;
            state_n = FETCH;
          end
        end
      end
      default: begin
        state_n = FETCH;
      end
    endcase
  end

  assign bus.oAddress     = pc;
  assign bus.oInstruction = ir;
  assign bus.oValid       = (state == ISSUE);
  assign bus.oBusy        = (state == DELAY);
  assign bus.dbg_state    = state;

endmodule
